// File: rtl/decoder_round_scheduler_pkg.sv
// Shared definitions for the round scheduler, the hubs and the PU stage decoders.
//   STATE_SIGNAL_WIDTH : width of the broadcast stage code
//   stage_e            : stage codes carried on downstream_state_signal
package decoder_round_scheduler_pkg;

  localparam int unsigned STATE_SIGNAL_WIDTH = 3;

  typedef enum logic [STATE_SIGNAL_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_RESULT              = 3'd4
  } stage_e;

endpackage

// File: rtl/decoder_round_scheduler_if.sv
// Control/status bundle between the round scheduler (master) and the root hub / host (slave).
//   new_round_start               : start pulse into the scheduler
//   downstream_has_message_flying : per-link in-flight flags into the scheduler
//   downstream_has_odd_clusters   : per-link odd-cluster flags into the scheduler
//   downstream_state_signal       : broadcast stage code
//   result_valid, iteration_counter, cycle_counter, deadlock, busy : round status
interface decoder_round_scheduler_if #(
  parameter int unsigned DOWNSTREAM_FIFO_COUNT   = 2,
  parameter int unsigned STATE_SIGNAL_WIDTH      = 3,
  parameter int unsigned ITERATION_COUNTER_WIDTH = 8
);
  logic                               new_round_start;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]   downstream_has_message_flying;
  logic [DOWNSTREAM_FIFO_COUNT-1:0]   downstream_has_odd_clusters;
  logic [STATE_SIGNAL_WIDTH-1:0]      downstream_state_signal;
  logic                               result_valid;
  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
  logic [31:0]                        cycle_counter;
  logic                               deadlock;
  logic                               busy;

  modport master (
    input  new_round_start, downstream_has_message_flying, downstream_has_odd_clusters,
    output downstream_state_signal, result_valid, iteration_counter, cycle_counter,
           deadlock, busy
  );

  modport slave (
    output new_round_start, downstream_has_message_flying, downstream_has_odd_clusters,
    input  downstream_state_signal, result_valid, iteration_counter, cycle_counter,
           deadlock, busy
  );
endinterface

// File: rtl/decoder_round_scheduler_merge_settle_detector.sv
// Quiet and timeout counters for one MERGE phase.
//   clk, reset    : clock, synchronous active-high reset
//   i_clear       : hold both counters at zero (asserted outside MERGE)
//   i_flying      : OR of the downstream message-flying flags
//   o_settled     : this cycle is the SETTLE_CYCLES-th consecutive quiet cycle
//   o_timed_out   : this cycle is the MERGE_TIMEOUT-th cycle of the merge
module merge_settle_detector #(
  parameter int unsigned SETTLE_CYCLES = 6,
  parameter int unsigned MERGE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_flying,
  output logic o_settled,
  output logic o_timed_out
);
  localparam int unsigned QW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned TW = (MERGE_TIMEOUT > 1) ? $clog2(MERGE_TIMEOUT + 1) : 1;

  logic [QW-1:0] r_quiet;
  logic [TW-1:0] r_timeout;

  // Both flags look at the count including the current cycle, so the FSM can
  // leave MERGE in the very cycle the threshold is reached.
  assign o_settled   = !i_clear && !i_flying && (r_quiet == QW'(SETTLE_CYCLES - 1));
  assign o_timed_out = !i_clear && (r_timeout == TW'(MERGE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_quiet   <= '0;
      r_timeout <= '0;
    end else begin
      r_quiet   <= i_flying ? '0 : ((r_quiet == '1) ? r_quiet : r_quiet + 1'b1);
      r_timeout <= (r_timeout == '1) ? r_timeout : r_timeout + 1'b1;
    end
  end
endmodule

// File: rtl/decoder_round_scheduler.sv
// Root-side sequencer for one decoding round across the hub tree.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of decoder_round_scheduler_if (start, flags in; stage code and
//                round status out)
module decoder_round_scheduler #(
  parameter int unsigned DOWNSTREAM_FIFO_COUNT   = 2,
  parameter int unsigned STATE_SIGNAL_WIDTH      = 3,
  parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
  parameter int unsigned MAX_ITERATIONS          = 16,
  parameter int unsigned LOAD_CYCLES             = 4,
  parameter int unsigned SETTLE_CYCLES           = 6,
  parameter int unsigned MERGE_TIMEOUT           = 1024
) (
  input logic                       clk,
  input logic                       reset,
  decoder_round_scheduler_if.master bus
);
  import decoder_round_scheduler_pkg::*;

  localparam int unsigned LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int unsigned IW = ITERATION_COUNTER_WIDTH;

  stage_e        r_state;
  logic [LW-1:0] r_load;
  logic [IW-1:0] r_iter;
  logic [31:0]   r_cycles;
  logic          r_deadlock;
  logic          r_valid;
  logic          r_busy;

  logic w_flying;
  logic w_odd;
  logic w_settled;
  logic w_timed_out;

  assign w_flying = |bus.downstream_has_message_flying;
  assign w_odd    = |bus.downstream_has_odd_clusters;

  merge_settle_detector #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MERGE_TIMEOUT (MERGE_TIMEOUT)
  ) u_settle (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (r_state != STAGE_MERGE),
    .i_flying    (w_flying),
    .o_settled   (w_settled),
    .o_timed_out (w_timed_out)
  );

  // Counters are updated on the edge entering the cycle they describe, so
  // cycle_counter already includes the RESULT cycle while result_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= STAGE_IDLE;
      r_load     <= '0;
      r_iter     <= '0;
      r_cycles   <= '0;
      r_deadlock <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state != STAGE_IDLE && r_state != STAGE_RESULT && r_cycles != '1)
        r_cycles <= r_cycles + 1'b1;
      unique case (r_state)
        STAGE_IDLE: begin
          if (bus.new_round_start) begin
            r_state    <= STAGE_MEASUREMENT_LOADING;
            r_load     <= '0;
            r_iter     <= '0;
            r_cycles   <= 32'd1;
            r_deadlock <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        STAGE_MEASUREMENT_LOADING: begin
          if (r_load == LW'(LOAD_CYCLES - 1)) begin
            r_state <= STAGE_GROW;
            r_iter  <= r_iter + 1'b1;
          end else begin
            r_load <= r_load + 1'b1;
          end
        end
        STAGE_GROW: r_state <= STAGE_MERGE;
        STAGE_MERGE: begin
          if (w_timed_out) begin
            r_state    <= STAGE_RESULT;
            r_deadlock <= 1'b1;
            r_valid    <= 1'b1;
          end else if (w_settled) begin
            if (!w_odd || r_iter == IW'(MAX_ITERATIONS)) begin
              r_state    <= STAGE_RESULT;
              r_deadlock <= w_odd;
              r_valid    <= 1'b1;
            end else begin
              r_state <= STAGE_GROW;
              r_iter  <= r_iter + 1'b1;
            end
          end
        end
        STAGE_RESULT: begin
          r_state <= STAGE_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= STAGE_IDLE;
      endcase
    end
  end

  assign bus.downstream_state_signal = STATE_SIGNAL_WIDTH'(r_state);
  assign bus.result_valid            = r_valid;
  assign bus.iteration_counter       = r_iter;
  assign bus.cycle_counter           = r_cycles;
  assign bus.deadlock                = r_deadlock;
  assign bus.busy                    = r_busy;
endmodule

// File: tb/tb_decoder_round_scheduler.sv
module tb_decoder_round_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] fly;
  logic [1:0] odd;
  bit         sel;          // 0: default DUT, 1: DUT with MERGE_TIMEOUT=32

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_round_scheduler_if #(.DOWNSTREAM_FIFO_COUNT(2), .STATE_SIGNAL_WIDTH(3),
                               .ITERATION_COUNTER_WIDTH(8)) bus0 ();
  decoder_round_scheduler_if #(.DOWNSTREAM_FIFO_COUNT(2), .STATE_SIGNAL_WIDTH(3),
                               .ITERATION_COUNTER_WIDTH(8)) bus1 ();

  assign bus0.new_round_start               = start & ~sel;
  assign bus0.downstream_has_message_flying = fly;
  assign bus0.downstream_has_odd_clusters   = odd;
  assign bus1.new_round_start               = start & sel;
  assign bus1.downstream_has_message_flying = fly;
  assign bus1.downstream_has_odd_clusters   = odd;

  decoder_round_scheduler u_dut (.clk(clk), .reset(reset), .bus(bus0));

  decoder_round_scheduler #(.MERGE_TIMEOUT(32)) u_dut_to (.clk(clk), .reset(reset), .bus(bus1));

  logic [2:0]  o_state;
  logic        o_valid;
  logic [7:0]  o_iter;
  logic [31:0] o_cycles;
  logic        o_dead;
  logic        o_busy;

  always_comb begin
    o_state  = sel ? bus1.downstream_state_signal : bus0.downstream_state_signal;
    o_valid  = sel ? bus1.result_valid            : bus0.result_valid;
    o_iter   = sel ? bus1.iteration_counter       : bus0.iteration_counter;
    o_cycles = sel ? bus1.cycle_counter           : bus0.cycle_counter;
    o_dead   = sel ? bus1.deadlock                : bus0.deadlock;
    o_busy   = sel ? bus1.busy                    : bus0.busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one round on the selected DUT, reacting to the observed stage each cycle.
  // Returns with the RESULT cycle visible on the outputs.
  task automatic run_round(input int odd_grows, input int fly_at, input bit fly_stuck,
                           input bit pulse_in_load, output int n_load, output int n_grow,
                           output int n_merge);
    int  merge_idx;
    bit  done;
    n_load = 0; n_grow = 0; n_merge = 0; merge_idx = 0; done = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("first_stage_after_start", 32'(o_state), 32'd1);
    for (int c = 0; c < 3000 && !done; c++) begin
      case (o_state)
        3'd1: n_load++;
        3'd2: begin n_grow++; merge_idx = 0; end
        3'd3: begin n_merge++; merge_idx++; end
        default: ;
      endcase
      odd   = (n_grow <= odd_grows) ? 2'b10 : 2'b00;
      fly   = fly_stuck ? 2'b11 : ((o_state == 3'd3 && merge_idx == fly_at) ? 2'b01 : 2'b00);
      start = pulse_in_load && o_state == 3'd1 && n_load == 2;
      if (o_valid) done = 1;
      else step();
    end
    start = 1'b0; fly = '0; odd = '0;
    if (!done) check_eq("round_timeout", 32'd0, 32'd1);
  endtask

  int nl, ng, nm;

  initial begin
    reset = 1'b1; start = 1'b0; fly = '0; odd = '0; sel = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check_eq("rst_state",  32'(o_state), 32'd0);
    check_eq("rst_valid",  32'(o_valid), 32'd0);
    check_eq("rst_iter",   32'(o_iter),  32'd0);
    check_eq("rst_cycles", o_cycles,     32'd0);
    check_eq("rst_dead",   32'(o_dead),  32'd0);
    check_eq("rst_busy",   32'(o_busy),  32'd0);

    // Minimum round
    run_round(0, 0, 1'b0, 1'b0, nl, ng, nm);
    check_eq("min_loads",  32'(nl), 32'd4);
    check_eq("min_grows",  32'(ng), 32'd1);
    check_eq("min_merges", 32'(nm), 32'd6);
    check_eq("min_state",  32'(o_state), 32'd4);
    check_eq("min_iter",   32'(o_iter), 32'd1);
    check_eq("min_cycles", o_cycles, 32'd12);
    check_eq("min_dead",   32'(o_dead), 32'd0);
    check_eq("min_busy",   32'(o_busy), 32'd1);
    step();
    check_eq("post_valid",  32'(o_valid), 32'd0);
    check_eq("post_busy",   32'(o_busy), 32'd0);
    check_eq("post_state",  32'(o_state), 32'd0);
    check_eq("hold_iter",   32'(o_iter), 32'd1);
    check_eq("hold_cycles", o_cycles, 32'd12);
    repeat (3) step();
    check_eq("hold_cycles_later", o_cycles, 32'd12);

    // Odd clusters during the first two merges
    run_round(2, 0, 1'b0, 1'b0, nl, ng, nm);
    check_eq("odd2_grows",  32'(ng), 32'd3);
    check_eq("odd2_iter",   32'(o_iter), 32'd3);
    check_eq("odd2_cycles", o_cycles, 32'd26);
    check_eq("odd2_dead",   32'(o_dead), 32'd0);
    step(); step();

    // Flying blip on the 5th merge cycle restarts the quiet count
    run_round(0, 5, 1'b0, 1'b0, nl, ng, nm);
    check_eq("blip_merges", 32'(nm), 32'd11);
    check_eq("blip_cycles", o_cycles, 32'd17);
    check_eq("blip_iter",   32'(o_iter), 32'd1);
    check_eq("blip_dead",   32'(o_dead), 32'd0);
    step(); step();

    // Odd stuck: iteration budget exhausted
    run_round(1000, 0, 1'b0, 1'b0, nl, ng, nm);
    check_eq("budget_grows",  32'(ng), 32'd16);
    check_eq("budget_iter",   32'(o_iter), 32'd16);
    check_eq("budget_dead",   32'(o_dead), 32'd1);
    check_eq("budget_cycles", o_cycles, 32'd117);
    step(); step();

    // Flying stuck on the short-timeout instance
    sel = 1'b1;
    step();
    run_round(0, 0, 1'b1, 1'b0, nl, ng, nm);
    check_eq("to_merges", 32'(nm), 32'd32);
    check_eq("to_dead",   32'(o_dead), 32'd1);
    check_eq("to_iter",   32'(o_iter), 32'd1);
    check_eq("to_cycles", o_cycles, 32'd38);
    step(); step();
    check_eq("to_hold_dead", 32'(o_dead), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("restart_dead",   32'(o_dead), 32'd0);
    check_eq("restart_iter",   32'(o_iter), 32'd0);
    check_eq("restart_cycles", o_cycles, 32'd1);
    repeat (20) step();
    check_eq("restart_dead_end",   32'(o_dead), 32'd0);
    check_eq("restart_cycles_end", o_cycles, 32'd12);
    sel = 1'b0;
    step();

    // Reset during MERGE
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50 && o_state != 3'd3; c++) step();
    check_eq("reached_merge", 32'(o_state), 32'd3);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_state",  32'(o_state), 32'd0);
    check_eq("mid_rst_iter",   32'(o_iter), 32'd0);
    check_eq("mid_rst_cycles", o_cycles, 32'd0);
    check_eq("mid_rst_busy",   32'(o_busy), 32'd0);
    step();
    check_eq("mid_rst_stays_idle", 32'(o_state), 32'd0);

    // Start pulse during LOADING is ignored
    run_round(0, 0, 1'b0, 1'b1, nl, ng, nm);
    check_eq("ign_loads",  32'(nl), 32'd4);
    check_eq("ign_cycles", o_cycles, 32'd12);
    check_eq("ign_iter",   32'(o_iter), 32'd1);
    step();
    check_eq("ign_idle", 32'(o_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
